// File: rtl/phv_action_aligner_if.sv
// Bundles the PHV/action data path, the handshake and the error/status
// outputs of phv_action_aligner.
//
// Handshake rules: a PHV moves from phv_in into the block on a clock edge where
// phv_valid_in and ready_out are both high. action_in has no backpressure and
// is taken or dropped on every edge where action_valid_in is high. A pair
// moves out on an edge where phv_valid_out and ready_in are both high. While a
// pair waits for ready_in, phv_out/action_out and the valid outputs hold still.
interface phv_action_aligner_if #(
  parameter int PHV_LEN = 48*8+32*8+16*8+256,
  parameter int ACT_LEN = 25
);
  logic [PHV_LEN-1:0]    phv_in;
  logic                  phv_valid_in;
  logic                  ready_out;
  logic [ACT_LEN*25-1:0] action_in;
  logic                  action_valid_in;
  logic [PHV_LEN-1:0]    phv_out;
  logic                  phv_valid_out;
  logic [ACT_LEN*25-1:0] action_out;
  logic                  action_valid_out;
  logic                  ready_in;
  logic                  overflow_err;
  logic                  orphan_err;
  logic [15:0]           drop_cnt;

  // Environment side: lookup front end plus action engine.
  modport master (
    output phv_in, phv_valid_in, action_in, action_valid_in, ready_in,
    input  ready_out, phv_out, phv_valid_out, action_out, action_valid_out,
    input  overflow_err, orphan_err, drop_cnt
  );

  // Aligner side.
  modport slave (
    input  phv_in, phv_valid_in, action_in, action_valid_in, ready_in,
    output ready_out, phv_out, phv_valid_out, action_out, action_valid_out,
    output overflow_err, orphan_err, drop_cnt
  );
endinterface

// File: rtl/phv_action_aligner.sv
// Pairs each buffered PHV, in arrival order, with the action word the lookup
// returns for it some cycles later, and presents the pair through a one-entry
// output register under ready backpressure.
module phv_action_aligner #(
  parameter int STAGE_ID = 0,
  parameter int PHV_LEN  = 48*8+32*8+16*8+256,
  parameter int ACT_LEN  = 25,
  parameter int ADDR_W   = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  phv_action_aligner_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int AW    = ACT_LEN * 25;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [PHV_LEN-1:0] phv_mem [DEPTH];
  logic [AW-1:0]      act_mem [DEPTH];

  logic [ADDR_W-1:0] phv_wr, phv_rd, act_wr, act_rd;
  logic [ADDR_W:0]   phv_cnt, act_cnt, unmatched;
  logic              phv_push, phv_drop, act_push, act_drop, load;
  logic [16:0]       drop_sum;

  // ready_out deliberately ignores a same-cycle pop, and is held low in reset.
  assign bus.ready_out        = rst_n & (phv_cnt != FULL_CNT);
  assign bus.action_valid_out = bus.phv_valid_out;

  // Push/drop decisions, output-register load and the next drop count.
  always_comb begin
    phv_push  = bus.phv_valid_in & bus.ready_out;
    phv_drop  = bus.phv_valid_in & ~bus.ready_out;
    unmatched = phv_cnt - act_cnt;
    // An action needs a PHV waiting for it, including one arriving this cycle.
    act_push  = bus.action_valid_in & ((unmatched != '0) | phv_push);
    act_drop  = bus.action_valid_in & ~act_push;
    load      = (phv_cnt != '0) & (act_cnt != '0) &
                (~bus.phv_valid_out | bus.ready_in);
    drop_sum  = {1'b0, bus.drop_cnt} + 17'(phv_drop) + 17'(act_drop);
  end

  // FIFO storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge clk) begin
    if (phv_push) phv_mem[phv_wr] <= bus.phv_in;
    if (act_push) act_mem[act_wr] <= bus.action_in;
  end

  // Pointers, counts, sticky errors, drop counter and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phv_wr            <= '0;
      phv_rd            <= '0;
      act_wr            <= '0;
      act_rd            <= '0;
      phv_cnt           <= '0;
      act_cnt           <= '0;
      bus.overflow_err  <= 1'b0;
      bus.orphan_err    <= 1'b0;
      bus.drop_cnt      <= '0;
      bus.phv_out       <= '0;
      bus.action_out    <= '0;
      bus.phv_valid_out <= 1'b0;
    end else begin
      if (phv_push) phv_wr <= phv_wr + 1'b1;
      if (act_push) act_wr <= act_wr + 1'b1;
      if (load) begin
        phv_rd <= phv_rd + 1'b1;
        act_rd <= act_rd + 1'b1;
      end
      phv_cnt          <= phv_cnt + (ADDR_W+1)'(phv_push) - (ADDR_W+1)'(load);
      act_cnt          <= act_cnt + (ADDR_W+1)'(act_push) - (ADDR_W+1)'(load);
      bus.overflow_err <= bus.overflow_err | phv_drop;
      bus.orphan_err   <= bus.orphan_err | act_drop;
      bus.drop_cnt     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (load) begin
        bus.phv_out       <= phv_mem[phv_rd];
        bus.action_out    <= act_mem[act_rd];
        bus.phv_valid_out <= 1'b1;
      end else if (bus.ready_in) begin
        bus.phv_valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_phv_action_aligner.sv
// Directed bench for phv_action_aligner: a vector table for the basic latency,
// reset and orphan cases, then hand-written multi-cycle sequences.
module tb_phv_action_aligner;
  localparam int PHV_LEN = 1024;
  localparam int ACT_LEN = 25;
  localparam int AW      = ACT_LEN * 25;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  phv_action_aligner_if #(.PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN)) bus();

  phv_action_aligner #(
    .STAGE_ID(0), .PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .ADDR_W(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data patterns ----------------
  function automatic logic [PHV_LEN-1:0] make_phv(input logic [31:0] t);
    return {32{t}};
  endfunction

  function automatic logic [AW-1:0] make_act(input logic [31:0] t);
    logic [24:0] s;
    s = t[24:0] ^ 25'h0155AA;
    return {25{s}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic pv, input logic av,
                       input logic [31:0] tag, input logic rdy);
    rst_n               = rst;
    bus.phv_valid_in    = pv;
    bus.phv_in          = make_phv(tag);
    bus.action_valid_in = av;
    bus.action_in       = make_act(tag);
    bus.ready_in        = rdy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    exp_q.delete();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.phv_valid_out) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_valid_low"}, 32'(bus.phv_valid_out), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  // Pairs are taken by the action engine on the next posedge; inputs are
  // stable from the previous posedge+1, so sampling at negedge is safe.
  always @(negedge clk) begin
    if (rst_n && bus.phv_valid_out) begin
      checks++;
      if (bus.action_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL action_valid_out: got %0b expected 1", bus.action_valid_out);
      end
      if (bus.ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pair: got phv %0h expected none", bus.phv_out[31:0]);
        end else begin
          logic [31:0] t;
          t = exp_q.pop_front();
          if (bus.phv_out !== make_phv(t) || bus.action_out !== make_act(t)) begin
            errors++;
            $display("FAIL pair_data: got phv %0h act %0h expected phv %0h act %0h",
                     bus.phv_out[31:0], bus.action_out[24:0], t, make_act(t)[24:0]);
          end
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        pv;
    logic        av;
    logic [31:0] tag;
    logic        rdy;
    logic        e_rdy;
    logic        e_vld;
    logic        e_ovf;
    logic        e_orph;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // rst pv av tag rdy | ready_out valid ovf orph drop (after the edge)
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h77,       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};

    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("rst_phv_out_zero", 32'(bus.phv_out != '0), 32'd0);
    chk("rst_action_out_zero", 32'(bus.action_out != '0), 32'd0);

    // Latency, single-cycle valid, reset and orphan action.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].av, vecs[i].tag, vecs[i].rdy);
      if (vecs[i].rst && vecs[i].pv) exp_q.push_back(vecs[i].tag);
      tick();
      if (!vecs[i].rst) exp_q.delete();
      chk($sformatf("vec%0d_ready_out", i), 32'(bus.ready_out), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(bus.phv_valid_out), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow_err), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_orphan", i), 32'(bus.orphan_err), 32'(vecs[i].e_orph));
      chk($sformatf("vec%0d_drop", i), 32'(bus.drop_cnt), 32'(vecs[i].e_drop));
    end
    chk("orphan_no_output_queue", 32'(exp_q.size()), 32'd0);

    // Fill the PHV FIFO, overflow it, then drain with late actions.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h100 + i, 1'b1);
      exp_q.push_back(32'h100 + i);
      tick();
      chk($sformatf("fill%0d_ready_out", i), 32'(bus.ready_out), 32'(i < 7));
    end
    drive(1'b1, 1'b1, 1'b0, 32'h1FF, 1'b1);
    tick();
    chk("ovf_flag", 32'(bus.overflow_err), 32'd1);
    chk("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd1);
    chk("ovf_ready_out", 32'(bus.ready_out), 32'd0);
    chk("ovf_no_output", 32'(bus.phv_valid_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h100 + i, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drain("ovf_drain");
    chk("ovf_drop_after", 32'(bus.drop_cnt), 32'd1);
    chk("ovf_orphan_after", 32'(bus.orphan_err), 32'd0);

    // Backpressure: 8 pairs with ready_in low, hold 5 cycles, then stream out.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h200 + i, 1'b0);
      exp_q.push_back(32'h200 + i);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d_valid", i), 32'(bus.phv_valid_out), 32'd1);
      chk($sformatf("hold%0d_phv", i), bus.phv_out[31:0], 32'h200);
      chk($sformatf("hold%0d_phv_full", i), 32'(bus.phv_out == make_phv(32'h200)), 32'd1);
    end
    bus.ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("stream%0d_valid", i), 32'(bus.phv_valid_out), 32'(i < 8));
    end
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Same-cycle pushes, 20 pairs back to back.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h300 + i, 1'b1);
      exp_q.push_back(32'h300 + i);
      tick();
      chk($sformatf("b2b%0d_ready_out", i), 32'(bus.ready_out), 32'd1);
      if (i > 0) chk($sformatf("b2b%0d_valid", i), 32'(bus.phv_valid_out), 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("b2b_last_valid", 32'(bus.phv_valid_out), 32'd1);
    tick();
    chk("b2b_done_valid", 32'(bus.phv_valid_out), 32'd0);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_errs", {30'd0, bus.overflow_err, bus.orphan_err}, 32'd0);
    chk("b2b_drop", 32'(bus.drop_cnt), 32'd0);

    // Reset mid-operation with 4 buffered and a pair waiting.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h500 + i, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_valid_before", 32'(bus.phv_valid_out), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("mid_rst_valid", 32'(bus.phv_valid_out), 32'd0);
    chk("mid_rst_action_valid", 32'(bus.action_valid_out), 32'd0);
    chk("mid_rst_phv_zero", 32'(bus.phv_out != '0), 32'd0);
    chk("mid_rst_act_zero", 32'(bus.action_out != '0), 32'd0);
    chk("mid_rst_ready_out", 32'(bus.ready_out), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("mid_rel_ready_out", 32'(bus.ready_out), 32'd1);
    chk("mid_rel_valid", 32'(bus.phv_valid_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h600 + i, 1'b1);
      exp_q.push_back(32'h600 + i);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drain("mid_drain");
    chk("mid_drop", 32'(bus.drop_cnt), 32'd0);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
